// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt arbiter: priority type, candidate payload, tree node compare.
package clic_pkg;

    localparam int unsigned CLIC_N_SOURCE = 32;
    localparam int unsigned CLIC_PRIO_W   = 8;
    localparam int unsigned CLIC_SRC_W    = $clog2(CLIC_N_SOURCE);

    typedef logic [CLIC_PRIO_W-1:0] prio_t;
    typedef logic [CLIC_SRC_W-1:0]  src_id_t;

    typedef struct packed {
        logic    valid;
        src_id_t id;
        prio_t   prio;
        logic    shv;
    } cand_t;

    // Pick the better of two candidates; 'lo' always holds the lower source index, so ties keep it.
    function automatic cand_t cand_pick(input cand_t lo, input cand_t hi);
        cand_t r;
        r = lo;
        if (hi.valid && (!lo.valid || (hi.prio > lo.prio))) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Combinational binary max-priority tree; ties resolve toward the lower source index at every node.
module clic_max_tree
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE = CLIC_N_SOURCE
) (
    input  cand_t cand_i [N_SOURCE],
    output cand_t win_o
);

    localparam int unsigned LEVELS = $clog2(N_SOURCE);
    localparam int unsigned N_LEAF = 1 << LEVELS;

    // Heap-ordered node array: node k has children 2k (lower indices) and 2k+1.
    cand_t w_node [1:2*N_LEAF-1];

    // Fill leaves (padding invalid), then reduce toward the root.
    always_comb begin
        for (int unsigned i = 1; i < 2 * N_LEAF; i++) begin
            w_node[i] = '0;
        end
        for (int unsigned i = 0; i < N_LEAF; i++) begin
            if (i < N_SOURCE) begin
                w_node[N_LEAF + i] = cand_i[i];
            end
        end
        for (int unsigned i = N_LEAF - 1; i >= 1; i--) begin
            w_node[i] = cand_pick(w_node[2 * i], w_node[2 * i + 1]);
        end
    end

    assign win_o = w_node[1];

endmodule

// File: rtl/clic_irq_arbiter.sv
// CLIC arbiter: registers the best pending interrupt and offers it to the hart with kill/claim support.
module clic_irq_arbiter
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE = CLIC_N_SOURCE,
    parameter int unsigned PRIO_W   = CLIC_PRIO_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_SOURCE-1:0]      ip_i,
    input  logic [N_SOURCE-1:0]      ie_i,
    input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
    input  logic [N_SOURCE-1:0]      shv_i,
    input  logic [PRIO_W-1:0]        thresh_i,
    output logic                     irq_valid_o,
    input  logic                     irq_ready_i,
    output logic [$clog2(N_SOURCE)-1:0] irq_id_o,
    output logic [PRIO_W-1:0]        irq_prio_o,
    output logic                     irq_shv_o,
    output logic                     irq_kill_req_o,
    input  logic                     irq_kill_ack_i,
    output logic [N_SOURCE-1:0]      claim_o
);

    localparam int unsigned SRC_W = $clog2(N_SOURCE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_KILL,
        S_HOLDOFF
    } state_t;

    cand_t   w_cand [N_SOURCE];
    cand_t   w_win;
    cand_t   r_cand;

    state_t  r_state, w_state_nxt;
    logic    r_valid, w_valid_nxt;
    logic    r_kill_req, w_kill_req_nxt;
    src_id_t r_id, w_id_nxt;
    prio_t   r_prio, w_prio_nxt;
    logic    r_shv, w_shv_nxt;

    // Per-source candidate qualification: pending, enabled and strictly above threshold.
    always_comb begin
        for (int unsigned i = 0; i < N_SOURCE; i++) begin
            w_cand[i].valid = ip_i[i] & ie_i[i] & (prio_i[i*PRIO_W +: PRIO_W] > thresh_i);
            w_cand[i].id    = SRC_W'(i);
            w_cand[i].prio  = prio_i[i*PRIO_W +: PRIO_W];
            w_cand[i].shv   = shv_i[i];
        end
    end

    clic_max_tree #(
        .N_SOURCE (N_SOURCE)
    ) u_max_tree (
        .cand_i (w_cand),
        .win_o  (w_win)
    );

    // Pipeline stage holding the current winner snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cand <= '0;
        end else begin
            r_cand <= w_win;
        end
    end

    // Offer FSM next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_valid_nxt    = r_valid;
        w_kill_req_nxt = r_kill_req;
        w_id_nxt       = r_id;
        w_prio_nxt     = r_prio;
        w_shv_nxt      = r_shv;
        unique case (r_state)
            S_IDLE: begin
                if (r_cand.valid) begin
                    w_state_nxt = S_OFFER;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = r_cand.id;
                    w_prio_nxt  = r_cand.prio;
                    w_shv_nxt   = r_cand.shv;
                end
            end
            S_OFFER: begin
                if (irq_ready_i) begin
                    w_state_nxt = S_HOLDOFF;
                    w_valid_nxt = 1'b0;
                end else if (!r_cand.valid || (r_cand.id != r_id)) begin
                    w_state_nxt    = S_KILL;
                    w_kill_req_nxt = 1'b1;
                end
            end
            S_KILL: begin
                // A late accept still wins over the withdrawal.
                if (irq_ready_i) begin
                    w_state_nxt    = S_HOLDOFF;
                    w_valid_nxt    = 1'b0;
                    w_kill_req_nxt = 1'b0;
                end else if (irq_kill_ack_i) begin
                    w_state_nxt    = S_IDLE;
                    w_valid_nxt    = 1'b0;
                    w_kill_req_nxt = 1'b0;
                end
            end
            S_HOLDOFF: begin
                // Candidate snapshot predates the claim; skip it for one cycle.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_valid_nxt    = 1'b0;
                w_kill_req_nxt = 1'b0;
            end
        endcase
    end

    // FSM state and registered offer outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_kill_req <= 1'b0;
            r_id       <= '0;
            r_prio     <= '0;
            r_shv      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= w_valid_nxt;
            r_kill_req <= w_kill_req_nxt;
            r_id       <= w_id_nxt;
            r_prio     <= w_prio_nxt;
            r_shv      <= w_shv_nxt;
        end
    end

    assign irq_valid_o    = r_valid;
    assign irq_kill_req_o = r_kill_req;
    assign irq_id_o       = r_id;
    assign irq_prio_o     = r_prio;
    assign irq_shv_o      = r_shv;

    // One-hot claim only during an accepted handshake.
    assign claim_o = (r_valid && irq_ready_i) ? (N_SOURCE'(1) << r_id) : '0;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed plus randomized bench for clic_irq_arbiter against a protocol-level reference model.
module tb_clic_irq_arbiter;

    localparam int unsigned N  = 32;
    localparam int unsigned PW = 8;
    localparam int unsigned SW = 5;

    localparam int PH_IDLE  = 0;
    localparam int PH_OFFER = 1;
    localparam int PH_KILL  = 2;
    localparam int PH_HOLD  = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    ip_i;
    logic [N-1:0]    ie_i;
    logic [N*PW-1:0] prio_i;
    logic [N-1:0]    shv_i;
    logic [PW-1:0]   thresh_i;
    logic            irq_valid_o;
    logic            irq_ready_i;
    logic [SW-1:0]   irq_id_o;
    logic [PW-1:0]   irq_prio_o;
    logic            irq_shv_o;
    logic            irq_kill_req_o;
    logic            irq_kill_ack_i;
    logic [N-1:0]    claim_o;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: registered candidate snapshot plus the offer the hart currently sees.
    bit m_cand_v;
    int m_cand_id, m_cand_p;
    bit m_cand_s;
    int m_phase;
    bit m_valid, m_kill;
    int m_id, m_prio;
    bit m_shv;

    always #5 clk_i = ~clk_i;

    clic_irq_arbiter #(.N_SOURCE(N), .PRIO_W(PW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ip_i           (ip_i),
        .ie_i           (ie_i),
        .prio_i         (prio_i),
        .shv_i          (shv_i),
        .thresh_i       (thresh_i),
        .irq_valid_o    (irq_valid_o),
        .irq_ready_i    (irq_ready_i),
        .irq_id_o       (irq_id_o),
        .irq_prio_o     (irq_prio_o),
        .irq_shv_o      (irq_shv_o),
        .irq_kill_req_o (irq_kill_req_o),
        .irq_kill_ack_i (irq_kill_ack_i),
        .claim_o        (claim_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_prio(input int idx, input int val);
        prio_i[idx*PW +: PW] = PW'(val);
    endtask

    // Highest priority among pending, enabled sources above threshold; first index wins ties.
    task automatic winner(output bit v, output int id, output int p, output bit s);
        int pr;
        v = 0; id = 0; p = 0; s = 0;
        for (int i = 0; i < int'(N); i++) begin
            pr = int'(prio_i[i*PW +: PW]);
            if (ip_i[i] && ie_i[i] && (pr > int'(thresh_i)) && (!v || pr > p)) begin
                v = 1; id = i; p = pr; s = shv_i[i];
            end
        end
    endtask

    task automatic model_reset();
        m_cand_v = 0; m_cand_id = 0; m_cand_p = 0; m_cand_s = 0;
        m_phase = PH_IDLE; m_valid = 0; m_kill = 0; m_id = 0; m_prio = 0; m_shv = 0;
    endtask

    // Apply the clock edge's effect on the model using the inputs currently driven.
    task automatic model_advance();
        bit wv; int wid; int wp; bit ws;
        winner(wv, wid, wp, ws);
        case (m_phase)
            PH_IDLE: if (m_cand_v) begin
                m_phase = PH_OFFER; m_valid = 1;
                m_id = m_cand_id; m_prio = m_cand_p; m_shv = m_cand_s;
            end
            PH_OFFER: begin
                if (irq_ready_i) begin
                    m_phase = PH_HOLD; m_valid = 0;
                end else if (!m_cand_v || m_cand_id != m_id) begin
                    m_phase = PH_KILL; m_kill = 1;
                end
            end
            PH_KILL: begin
                if (irq_ready_i) begin
                    m_phase = PH_HOLD; m_valid = 0; m_kill = 0;
                end else if (irq_kill_ack_i) begin
                    m_phase = PH_IDLE; m_valid = 0; m_kill = 0;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
        m_cand_v = wv; m_cand_id = wid; m_cand_p = wp; m_cand_s = ws;
    endtask

    // Compare outputs with the model, then advance one clock.
    task automatic run_cycle();
        logic [63:0] exp_claim;
        #1;
        chk("valid", 64'(irq_valid_o), 64'(m_valid));
        chk("kill_req", 64'(irq_kill_req_o), 64'(m_kill));
        exp_claim = (m_valid && irq_ready_i) ? (64'(1) << m_id) : 64'(0);
        chk("claim", 64'(claim_o), exp_claim);
        if (m_valid) begin
            chk("id", 64'(irq_id_o), 64'(m_id));
            chk("prio", 64'(irq_prio_o), 64'(m_prio));
            chk("shv", 64'(irq_shv_o), 64'(m_shv));
        end
        model_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    // Drain any open offer by accepting it, then settle in idle.
    task automatic flush();
        ip_i = '0; ie_i = '1; irq_kill_ack_i = 0; irq_ready_i = 1;
        run_cycle();
        irq_ready_i = 0;
        run_n(3);
        chk("flush_idle", 64'(irq_valid_o), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(irq_valid_o), 64'(0));
        chk({tag, "_kill"}, 64'(irq_kill_req_o), 64'(0));
        chk({tag, "_id"}, 64'(irq_id_o), 64'(0));
        chk({tag, "_prio"}, 64'(irq_prio_o), 64'(0));
        chk({tag, "_shv"}, 64'(irq_shv_o), 64'(0));
        chk({tag, "_claim"}, 64'(claim_o), 64'(0));
    endtask

    initial begin
        rst_ni = 0; ip_i = '0; ie_i = '1; prio_i = '0; shv_i = '0; thresh_i = '0;
        irq_ready_i = 0; irq_kill_ack_i = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1;

        // Single source, 2-cycle latency, claim pulse.
        set_prio(5, 8'h40); shv_i[5] = 1; ip_i[5] = 1;
        run_cycle();
        chk("t1_lat1", 64'(irq_valid_o), 64'(0));
        run_cycle();
        chk("t1_valid", 64'(irq_valid_o), 64'(1));
        chk("t1_id", 64'(irq_id_o), 64'(5));
        chk("t1_prio", 64'(irq_prio_o), 64'h40);
        irq_ready_i = 1; #1;
        chk("t1_claim", 64'(claim_o), 64'h20);
        run_cycle();
        irq_ready_i = 0; ip_i[5] = 0;
        chk("t1_hold", 64'(irq_valid_o), 64'(0));
        chk("t1_hold_claim", 64'(claim_o), 64'(0));
        run_n(3);
        chk("t1_edge_no_reoffer", 64'(irq_valid_o), 64'(0));
        shv_i = '0;

        // Priority with tie-break, then disable winner -> kill path to next.
        set_prio(3, 8'h10); set_prio(7, 8'h80); set_prio(9, 8'h80);
        ip_i[3] = 1; ip_i[7] = 1; ip_i[9] = 1;
        run_n(2);
        chk("t2_id", 64'(irq_id_o), 64'(7));
        ie_i[7] = 0;
        run_n(2);
        chk("t2_kill", 64'(irq_kill_req_o), 64'(1));
        chk("t2_kill_valid", 64'(irq_valid_o), 64'(1));
        chk("t2_kill_id", 64'(irq_id_o), 64'(7));
        irq_kill_ack_i = 1;
        run_cycle();
        irq_kill_ack_i = 0;
        chk("t2_ack_valid", 64'(irq_valid_o), 64'(0));
        chk("t2_ack_kill", 64'(irq_kill_req_o), 64'(0));
        run_cycle();
        chk("t2_reoffer", 64'(irq_id_o), 64'(9));
        chk("t2_reoffer_v", 64'(irq_valid_o), 64'(1));
        flush();

        // Threshold is a strict compare.
        set_prio(2, 8'h30); thresh_i = 8'h30; ip_i[2] = 1;
        run_n(3);
        chk("t3_equal_thresh", 64'(irq_valid_o), 64'(0));
        thresh_i = 8'h2F;
        run_cycle();
        chk("t3_lat1", 64'(irq_valid_o), 64'(0));
        run_cycle();
        chk("t3_valid", 64'(irq_valid_o), 64'(1));
        chk("t3_id", 64'(irq_id_o), 64'(2));
        flush();
        thresh_i = '0;

        // Preemption by a higher source through kill/ack.
        set_prio(4, 8'h20); set_prio(6, 8'h90); ip_i[4] = 1;
        run_n(2);
        chk("t4_id4", 64'(irq_id_o), 64'(4));
        ip_i[6] = 1;
        run_n(2);
        chk("t4_kill", 64'(irq_kill_req_o), 64'(1));
        irq_kill_ack_i = 1;
        run_cycle();
        irq_kill_ack_i = 0;
        chk("t4_idle", 64'(irq_valid_o), 64'(0));
        run_cycle();
        chk("t4_id6", 64'(irq_id_o), 64'(6));
        flush();

        // Ready and kill-ack together: ready wins.
        ip_i[4] = 1;
        run_n(2);
        ip_i[6] = 1;
        run_n(2);
        chk("t5_kill", 64'(irq_kill_req_o), 64'(1));
        irq_ready_i = 1; irq_kill_ack_i = 1; #1;
        chk("t5_claim", 64'(claim_o), 64'h10);
        run_cycle();
        irq_ready_i = 0; irq_kill_ack_i = 0; ip_i[4] = 0;
        chk("t5_kill_drop", 64'(irq_kill_req_o), 64'(0));
        chk("t5_valid_drop", 64'(irq_valid_o), 64'(0));
        run_cycle();
        chk("t5_holdoff", 64'(irq_valid_o), 64'(0));
        run_cycle();
        chk("t5_next_id", 64'(irq_id_o), 64'(6));
        flush();

        // Asynchronous reset mid-offer, then level re-offer.
        ip_i[4] = 1;
        run_n(2);
        chk("t6_offer", 64'(irq_valid_o), 64'(1));
        #2;
        rst_ni = 0; irq_ready_i = 1; #1;
        check_all_zero("t6_rst");
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1; irq_ready_i = 0;
        run_cycle();
        chk("t6_lat1", 64'(irq_valid_o), 64'(0));
        run_cycle();
        chk("t6_reoffer", 64'(irq_valid_o), 64'(1));
        chk("t6_id", 64'(irq_id_o), 64'(4));
        flush();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) begin
                for (int i = 0; i < int'(N); i++) begin
                    case ($urandom_range(0, 4))
                        0: set_prio(i, 8'h10);
                        1: set_prio(i, 8'h40);
                        2: set_prio(i, 8'h80);
                        default: set_prio(i, int'($urandom_range(0, 255)));
                    endcase
                end
                shv_i = $urandom;
            end
            if ($urandom_range(0, 3) == 0) ip_i = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) ie_i = ~($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) thresh_i = PW'($urandom_range(0, 8'h60));
            irq_ready_i    = ($urandom_range(0, 3) == 0);
            irq_kill_ack_i = ($urandom_range(0, 2) == 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
